// File: rtl/cntry_car_sensor.sv
// cntry_car_sensor: country-road vehicle loop sensor.
// A two-flop synchronizer and a debouncer turn the raw loop detector into a
// clean presence signal (det). Rising edges of det queue a car, falling edges
// while the country road is GREEN release one. A small FSM (IDLE/REQ/SERVE)
// drives the registered request X to the signal controller.
// Optional gap-out (macro CNTRY_GAPOUT_EN): while serving, GAP_CYCLES
// consecutive empty-loop cycles clear the queue and pulse gapout.
module cntry_car_sensor #(
   parameter int unsigned DEB_CYCLES = 3,
   parameter int unsigned GAP_CYCLES = 8,
   parameter int unsigned CNT_W      = 4
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             loop_raw,
   input  logic [1:0]       cntry,
   output logic             X,
   output logic [CNT_W-1:0] car_count,
   output logic             overflow,
   output logic             gapout
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      SERVE = 2'd2
   } state_t;

   localparam logic [1:0]       CNTRY_GREEN = 2'b10;
   localparam logic [3:0]       DEB_LAST    = 4'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   // Parameter range guards, evaluated at elaboration.
   if (DEB_CYCLES < 1 || DEB_CYCLES > 15) begin : g_bad_deb
      $error("cntry_car_sensor: DEB_CYCLES must be 1..15");
   end
   if (GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_bad_gap
      $error("cntry_car_sensor: GAP_CYCLES must be 1..255");
   end
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("cntry_car_sensor: CNT_W must be at least 1");
   end

   logic             sync_1;
   logic             sync_2;
   logic [3:0]       deb_cnt;
   logic             det;
   logic             det_d;
   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] count_nxt;
   logic             ovf_nxt;
   logic             green;
   logic             arrival;
   logic             departure;
   logic             gap_hit;

   // Code 2'b11 is not GREEN, so it behaves like RED everywhere below.
   assign green     = (cntry == CNTRY_GREEN);
   assign arrival   = det & ~det_d;
   assign departure = ~det & det_d & green;

   // Two-flop synchronizer for the asynchronous loop detector.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
      end else begin
         sync_1 <= loop_raw;
         sync_2 <= sync_1;
      end
   end

   // Debouncer: det follows sync_2 only after DEB_CYCLES consecutive
   // disagreeing samples; any agreeing sample restarts the count.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         deb_cnt <= '0;
         det     <= 1'b0;
         det_d   <= 1'b0;
      end else begin
         det_d <= det;
         if (sync_2 == det) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DEB_LAST) begin
            det     <= sync_2;
            deb_cnt <= '0;
         end else begin
            deb_cnt <= deb_cnt + 4'd1;
         end
      end
   end

`ifdef CNTRY_GAPOUT_EN
   localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

   logic [7:0] gap_cnt;
   logic [7:0] gap_nxt;

   // Gap counter: runs only while serving with an empty loop on GREEN.
   always_comb begin
      gap_nxt = '0;
      gap_hit = 1'b0;
      if ((state == SERVE) && green && !det) begin
         if (gap_cnt == GAP_LAST) begin
            gap_hit = 1'b1;
         end else begin
            gap_nxt = gap_cnt + 8'd1;
         end
      end
   end

   // Gap counter and registered one-cycle gap-out pulse.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         gap_cnt <= '0;
         gapout  <= 1'b0;
      end else begin
         gap_cnt <= gap_nxt;
         gapout  <= gap_hit;
      end
   end
`else
   assign gap_hit = 1'b0;
   assign gapout  = 1'b0;
`endif

   // Queue arithmetic and FSM next state; state follows the next-cycle count
   // so X rises/falls on the same edge the count leaves/reaches zero.
   always_comb begin
      count_nxt = car_count;
      ovf_nxt   = overflow;
      state_nxt = IDLE;
      if (arrival) begin
         if (car_count == CNT_MAX) begin
            ovf_nxt = 1'b1;
         end else begin
            count_nxt = car_count + CNT_ONE;
         end
      end else if (departure && (car_count != '0)) begin
         count_nxt = car_count - CNT_ONE;
      end
      if (gap_hit) begin
         count_nxt = '0;
      end
      if (count_nxt == '0) begin
         state_nxt = IDLE;
      end else if (green) begin
         state_nxt = SERVE;
      end else begin
         state_nxt = REQ;
      end
   end

   // FSM state register and the registered request output.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state <= IDLE;
         X     <= 1'b0;
      end else begin
         state <= state_nxt;
         X     <= (state_nxt != IDLE);
      end
   end

   // Car counter and sticky overflow flag.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         car_count <= '0;
         overflow  <= 1'b0;
      end else begin
         car_count <= count_nxt;
         overflow  <= ovf_nxt;
      end
   end

endmodule

// File: doc/cntry_car_sensor.md
CNTRY_CAR_SENSOR -- requirements
Module: cntry_car_sensor

Interface
REQ-001 Parameter DEB_CYCLES, default 3: consecutive synchronized samples needed to change the debounced presence (range 1-15).
REQ-002 Parameter GAP_CYCLES, default 8: consecutive empty-loop cycles during country green that trigger a gap-out (range 1-255).
REQ-003 Parameter CNT_W, default 4: width of the waiting-car counter.
REQ-004 clock  input  1  system clock; all state updates on the rising edge.
REQ-005 clear  input  1  asynchronous, active-low reset.
REQ-006 loop_raw  input  1  raw, asynchronous, bouncy country-road loop detector; 1 = vehicle present.
REQ-007 cntry  input  2  country-road signal from the signal controller: 2'b00 RED, 2'b01 YELLOW, 2'b10 GREEN; 2'b11 is treated as RED.
REQ-008 X  output  1  registered car-waiting request to the signal controller.
REQ-009 car_count  output  CNT_W  registered number of cars waiting or being served.
REQ-010 overflow  output  1  sticky flag: an arrival occurred with car_count at its maximum.
REQ-011 gapout  output  1  one-cycle pulse when car_count is force-cleared by a gap-out.

Function
REQ-012 loop_raw shall pass through a two-flop synchronizer before any other use.
REQ-013 Debounced presence det shall take the synchronized value only after that value has differed from det for DEB_CYCLES consecutive cycles; any agreeing sample in between restarts the debounce count.
REQ-014 An arrival is a 0->1 transition of det; a departure is a 1->0 transition of det while cntry == GREEN.
REQ-015 On an arrival, car_count shall increment by 1 and saturate at 2^CNT_W-1; an arrival at saturation shall set overflow.
REQ-016 On a departure, car_count shall decrement by 1 and never go below 0; a departure at 0 is ignored.
REQ-017 A 1->0 transition of det while cntry != GREEN shall not change car_count, because the car is still queued.
REQ-018 The FSM states shall be IDLE (car_count == 0), REQ (car_count > 0 and cntry != GREEN) and SERVE (car_count > 0 and cntry == GREEN), with the state re-evaluated every cycle from the next-cycle car_count and the current cntry.
REQ-019 X shall be 1 exactly when the registered state is REQ or SERVE.
REQ-020 Latency: a clean loop_raw rise from IDLE shall assert X on rising edge DEB_CYCLES+3 (2 synchronizer edges, DEB_CYCLES debounce edges, 1 output-register edge).
REQ-021 When cntry leaves GREEN while car_count > 0, the state shall return to REQ and X shall stay 1.
REQ-022 When a departure brings car_count to 0, X shall drop on the same edge on which car_count becomes 0.

Reset
REQ-023 While clear == 0, the block shall force X=0, car_count=0, overflow=0, gapout=0, state IDLE, det=0, synchronizer flops=0, debounce counter=0 and gap counter=0, independently of clock.
REQ-024 Reset deassertion during an active loop_raw shall count that car as a new arrival after the normal REQ-020 latency.

Configuration
REQ-025 Macro CNTRY_GAPOUT_EN enables gap-out: in SERVE, the gap counter increments each cycle det == 0 and clears whenever det == 1 or cntry != GREEN.
REQ-026 With CNTRY_GAPOUT_EN defined, when the gap counter reaches GAP_CYCLES, car_count shall clear to 0, gapout shall pulse for 1 cycle, X shall drop on the same edge, and the gap counter shall clear.
REQ-027 With CNTRY_GAPOUT_EN undefined, the gap counter shall not exist, gapout shall be tied to 0, and car_count shall change only per REQ-015 and REQ-016.

Verification
REQ-028 Settings for all scenarios: DEB_CYCLES=3, GAP_CYCLES=8, CNT_W=4, cntry=RED, reset released; loop_raw high for 10 cycles -> X=1 on edge 6, car_count=1, and car_count stays 1 after loop_raw falls.
REQ-029 With cntry=RED, toggle loop_raw 1/0 every cycle for 20 cycles -> det never changes, car_count stays 0, X stays 0.
REQ-030 With cntry=RED, apply 3 clean car pulses, then cntry=GREEN and 3 clean pulses -> car_count goes 1,2,3 then 2,1,0, and X=0 on the edge car_count reaches 0.
REQ-031 Apply 16 clean arrivals while RED -> car_count saturates at 15 and overflow=1 and stays 1 until clear.
REQ-032 With CNTRY_GAPOUT_EN defined, car_count=2, then cntry=GREEN with the loop empty -> on the 8th cycle car_count=0, gapout pulses 1 cycle, X=0; without the macro car_count stays 2 and gapout stays 0.
REQ-033 Assert clear mid-debounce and mid-SERVE -> all outputs reach 0 immediately without waiting for a clock edge, and normal operation resumes after release.
